// File: rtl/shift_pkg.sv
// Shared shifter definitions: default sizes, op encodings and FSM states.
package shift_pkg;
  localparam int SHR_WIDTH = 16;
  localparam int SHR_CNT_W = 4;

  localparam logic [1:0] SHR_LOGIC = 2'b00;
  localparam logic [1:0] SHR_ARITH = 2'b01;
  localparam logic [1:0] SHR_ROT   = 2'b10;

  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/shift_right_seq_if.sv
// Request/response bus between the ALU and the sequential right shifter.
interface shift_right_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] In;
  logic [CNT_W-1:0] Cnt;
  logic [1:0]       Op;
  logic [WIDTH-1:0] Out;
  logic             busy;
  logic             done;

  modport master (output start, In, Cnt, Op, input Out, busy, done);
  modport slave  (input start, In, Cnt, Op, output Out, busy, done);
endinterface

// File: rtl/shift_right_stage.sv
// One logarithmic stage: optional right shift/rotate by a power-of-two amount.
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = SHR_WIDTH,
  parameter int CNT_W = SHR_CNT_W
) (
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] amount,
  input  logic             enable,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH-1:0] lsr, hi_mask, wrap;
  logic [CNT_W:0]   back;

  // Single mux level per stage: pass through, or pick the filled shift result.
  always_comb begin
    back    = (CNT_W+1)'(WIDTH) - {1'b0, amount};
    lsr     = data >> amount;
    hi_mask = ~({WIDTH{1'b1}} >> amount);
    wrap    = data << back;
    res     = data;
    if (enable) begin
      case (op)
        SHR_ARITH: res = lsr | (data[WIDTH-1] ? hi_mask : '0);
        SHR_ROT:   res = lsr | wrap;
        default:   res = lsr;  // logical, and 2'b11 aliases to logical
      endcase
    end
  end
endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter/rotator: one log stage per cycle, fixed latency.
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = SHR_WIDTH,
  parameter int CNT_W = SHR_CNT_W
) (
  input logic              clk,
  input logic              rst,
  shift_right_seq_if.slave bus
);
  localparam int SW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [SW-1:0] LAST = SW'(CNT_W - 1);

  state_t           state;
  logic [WIDTH-1:0] data_r, stage_res;
  logic [CNT_W-1:0] cnt_r, amount;
  logic [1:0]       op_r;
  logic [SW-1:0]    stage;

  // Stage k shifts by 2^k when cnt_r[k] is set.
  always_comb amount = CNT_W'(1) << stage;

  shift_right_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage (
    .data   (data_r),
    .amount (amount),
    .enable (cnt_r[stage]),
    .op     (op_r),
    .res    (stage_res)
  );

  // Control FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_r   <= '0;
      cnt_r    <= '0;
      op_r     <= '0;
      stage    <= '0;
      bus.Out  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_r   <= bus.In;
            cnt_r    <= bus.Cnt;
            op_r     <= bus.Op;
            stage    <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          data_r <= stage_res;
          stage  <= stage + 1'b1;
          if (stage == LAST) begin
            bus.Out  <= stage_res;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: vector table plus handshake corners.
module tb_shift_right_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_right_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

  shift_right_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [15:0] exp;
    bit          scramble;
  } vec_t;

  vec_t        tbl[8];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference for random vectors.
  function automatic logic [15:0] ref_shr(input logic [15:0] in, input logic [3:0] cnt,
                                          input logic [1:0] op);
    logic [15:0] r;
    case (op)
      2'b01:   r = $signed(in) >>> cnt;
      2'b10:   r = (cnt == 0) ? in : ((in >> cnt) | (in << (16 - int'(cnt))));
      default: r = in >> cnt;
    endcase
    return r;
  endfunction

  // Scoreboard: every done pops one expected result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else chk("out", bus.Out, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [15:0] in, input logic [3:0] cnt, input logic [1:0] op,
                       input logic [15:0] exp, input bit scramble);
    int lat;
    bit found;
    @(negedge clk);
    bus.start = 1'b1; bus.In = in; bus.Cnt = cnt; bus.Op = op;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    bus.start = 1'b0;
    chk("busy_after_accept", bus.busy, 1'b1);
    if (scramble) begin
      bus.In = ~in; bus.Cnt = ~cnt; bus.Op = op ^ 2'b01;
    end
    lat = 0; found = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin found = 1; break; end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
    else begin
      chk("latency", lat, 4);
      chk("busy_in_done", bus.busy, 1'b0);
    end
  endtask

  initial begin
    int d0, last_done, gap, ndone;
    logic [15:0] rin;
    logic [3:0]  rcnt;
    logic [1:0]  rop;

    tbl[0] = '{16'h8001, 4'd1,  2'b00, 16'h4000, 1'b0};
    tbl[1] = '{16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0};
    tbl[2] = '{16'h7FF0, 4'd4,  2'b01, 16'h07FF, 1'b1};
    tbl[3] = '{16'h0001, 4'd4,  2'b10, 16'h1000, 1'b0};
    tbl[4] = '{16'hABCD, 4'd8,  2'b10, 16'hCDAB, 1'b1};
    tbl[5] = '{16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0};
    tbl[6] = '{16'hF000, 4'd4,  2'b11, 16'h0F00, 1'b0};
    tbl[7] = '{16'h8421, 4'd15, 2'b10, 16'h0843, 1'b1};

    bus.start = 1'b0; bus.In = '0; bus.Cnt = '0; bus.Op = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", bus.Out, 16'h0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) do_op(tbl[i].in, tbl[i].cnt, tbl[i].op, tbl[i].exp, tbl[i].scramble);

    for (int i = 0; i < 8; i++) begin
      rin  = 16'($urandom);
      rcnt = 4'($urandom_range(0, 15));
      rop  = 2'($urandom_range(0, 3));
      do_op(rin, rcnt, rop, ref_shr(rin, rcnt, rop), 1'b0);
    end

    // start held high: accepted whenever the FSM is idle.
    @(negedge clk);
    bus.start = 1'b1; bus.In = 16'h00F0; bus.Cnt = 4'd4; bus.Op = 2'b00;
    d0 = done_cnt; last_done = -1; gap = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.busy) exp_q.push_back(16'h000F);
      @(posedge clk);
      #1;
      if (bus.done) begin
        // Four shift cycles plus the idle cycle in which the next start is taken.
        if (last_done >= 0) chk("held_start_gap", c - last_done, 5);
        last_done = c;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("held_start_dones", done_cnt - d0, 4);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("held_start_drain", exp_q.size(), 0);

    // start pulsed while busy is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.In = 16'h0F0F; bus.Cnt = 4'd2; bus.Op = 2'b00;
    d0 = done_cnt;
    @(posedge clk);
    exp_q.push_back(16'h03C3);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.In = 16'hFFFF; bus.Cnt = 4'd1; bus.Op = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("busy_start_single_done", done_cnt - d0, 1);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    bus.start = 1'b1; bus.In = 16'hFFFF; bus.Cnt = 4'd3; bus.Op = 2'b00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_out", bus.Out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 0);
    do_op(16'hC000, 4'd2, 2'b01, 16'hF000, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
